midi_voice_alloc: RTL and testbench

//  Polyphonic voice allocator between the MIDI byte receiver and the tone generators.

---
 rtl/midi_voice_alloc_if.sv | 32 +++
 rtl/midi_voice_alloc.sv | 200 ++++++++++++++++++++
 tb/tb_midi_voice_alloc.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/midi_voice_alloc_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | midi_voice_alloc_if : command bus from the MIDI receiver plus the   |
// |                       per-voice bus consumed by the generator bank  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface midi_voice_alloc_if #(
  parameter int NUM_VOICES = 4
);
  logic                    midi_command_ready;
  logic [3:0]              ch_message;
  logic [3:0]              chan;
  logic [6:0]              note_in;
  logic [6:0]              velocity_in;
  logic [NUM_VOICES-1:0]   gate;
  logic [7*NUM_VOICES-1:0] note_out;
  logic [7*NUM_VOICES-1:0] velocity_out;
  logic                    busy;
  logic                    done;
  logic                    drop;

  modport master (
    output midi_command_ready, ch_message, chan, note_in, velocity_in,
    input  gate, note_out, velocity_out, busy, done, drop
  );

  modport slave (
    input  midi_command_ready, ch_message, chan, note_in, velocity_in,
    output gate, note_out, velocity_out, busy, done, drop
  );
endinterface
`default_nettype wire

// File: rtl/midi_voice_alloc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | midi_voice_alloc : polyphonic Note On/Off voice allocator with      |
// |                    retrigger, first-free and oldest-steal policy    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int AGE_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [3:0]        chan_sel,
  midi_voice_alloc_if.slave bus
);

  localparam int                 c_idx_w      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx   = c_idx_w'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0]   c_age_max    = AGE_W'(NUM_VOICES - 1);
  localparam logic [6:0]         c_cc_all_off = 7'd123;
  localparam logic [3:0]         c_st_off     = 4'b1000;
  localparam logic [3:0]         c_st_on      = 4'b1001;
  localparam logic [3:0]         c_st_cc      = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCAN   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    OP_ON      = 2'd0,
    OP_OFF     = 2'd1,
    OP_ALL_OFF = 2'd2
  } op_t;

  state_t               r_state;
  op_t                  r_op;
  logic                 r_ready_d;
  logic [6:0]           r_note;
  logic [6:0]           r_vel;
  logic [c_idx_w-1:0]   r_idx;
  logic                 r_match_found;
  logic [c_idx_w-1:0]   r_match_idx;
  logic                 r_free_found;
  logic [c_idx_w-1:0]   r_free_idx;
  logic [c_idx_w-1:0]   r_oldest_idx;
  logic [AGE_W-1:0]     r_oldest_age;
  logic [NUM_VOICES-1:0] r_gate;
  logic [6:0]           r_notes [NUM_VOICES];
  logic [6:0]           r_vels  [NUM_VOICES];
  logic [AGE_W-1:0]     r_age   [NUM_VOICES];
  logic                 r_busy;
  logic                 r_done;
  logic                 r_drop;

  logic                    w_accept;
  logic                    w_is_on;
  logic                    w_is_off;
  logic                    w_is_all_off;
  logic                    w_cur_gate;
  logic [6:0]              w_cur_note;
  logic [AGE_W-1:0]        w_cur_age;
  logic                    w_cur_match;
  logic [c_idx_w-1:0]      w_target;
  logic [7*NUM_VOICES-1:0] w_note_bus;
  logic [7*NUM_VOICES-1:0] w_vel_bus;

  assign w_accept     = bus.midi_command_ready & ~r_ready_d & en & (bus.chan == chan_sel);
  assign w_is_on      = (bus.ch_message == c_st_on) && (bus.velocity_in != 7'd0);
  assign w_is_off     = (bus.ch_message == c_st_off) ||
                        ((bus.ch_message == c_st_on) && (bus.velocity_in == 7'd0));
  assign w_is_all_off = (bus.ch_message == c_st_cc) && (bus.note_in == c_cc_all_off);

  assign w_cur_gate  = r_gate[r_idx];
  assign w_cur_note  = r_notes[r_idx];
  assign w_cur_age   = r_age[r_idx];
  assign w_cur_match = w_cur_gate && (w_cur_note == r_note);

  // Retrigger beats a free slot, which beats stealing the oldest one.
  assign w_target = r_match_found ? r_match_idx :
                    r_free_found  ? r_free_idx  : r_oldest_idx;

  always_comb begin
    w_note_bus = '0;
    w_vel_bus  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      w_note_bus[7*i +: 7] = r_notes[i];
      w_vel_bus[7*i +: 7]  = r_vels[i];
    end
  end

  assign bus.gate         = r_gate;
  assign bus.note_out     = w_note_bus;
  assign bus.velocity_out = w_vel_bus;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.drop         = r_drop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_op          <= OP_ON;
      r_ready_d     <= 1'b0;
      r_note        <= '0;
      r_vel         <= '0;
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_oldest_idx  <= '0;
      r_oldest_age  <= '0;
      r_gate        <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_drop        <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_notes[i] <= '0;
        r_vels[i]  <= '0;
        r_age[i]   <= '0;
      end
    end else begin
      r_ready_d <= bus.midi_command_ready;
      r_done    <= 1'b0;
      r_drop    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_note        <= bus.note_in;
            r_vel         <= bus.velocity_in;
            r_idx         <= '0;
            r_match_found <= 1'b0;
            r_match_idx   <= '0;
            r_free_found  <= 1'b0;
            r_free_idx    <= '0;
            r_oldest_idx  <= '0;
            r_oldest_age  <= '0;
            if (w_is_on || w_is_off) begin
              r_op    <= w_is_on ? OP_ON : OP_OFF;
              r_state <= S_SCAN;
              r_busy  <= 1'b1;
            end else if (w_is_all_off) begin
              r_op    <= OP_ALL_OFF;
              r_state <= S_COMMIT;
              r_busy  <= 1'b1;
            end
          end
        end
        S_SCAN: begin
          if (w_accept) r_drop <= 1'b1;
          if (!r_match_found && w_cur_match) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_idx;
          end
          if (!r_free_found && !w_cur_gate) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          // Strict compare keeps the lowest index on equal ages.
          if (w_cur_age > r_oldest_age) begin
            r_oldest_age <= w_cur_age;
            r_oldest_idx <= r_idx;
          end
          if (r_idx == c_last_idx) r_state <= S_COMMIT;
          else                     r_idx   <= r_idx + 1'b1;
        end
        S_COMMIT: begin
          if (w_accept) r_drop <= 1'b1;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
          case (r_op)
            OP_ON: begin
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (c_idx_w'(i) == w_target) begin
                  r_gate[i]  <= 1'b1;
                  r_notes[i] <= r_note;
                  r_vels[i]  <= r_vel;
                  r_age[i]   <= '0;
                end else if (r_age[i] < c_age_max) begin
                  r_age[i] <= r_age[i] + 1'b1;
                end
              end
            end
            OP_OFF: begin
              if (r_match_found) r_gate[r_match_idx] <= 1'b0;
            end
            OP_ALL_OFF: r_gate <= '0;
            default: ;
          endcase
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_midi_voice_alloc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_midi_voice_alloc : bench for midi_voice_alloc with a cycle model |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_midi_voice_alloc;
  localparam int         NV  = 4;
  localparam int         AW  = 4;
  localparam logic [3:0] SEL = 4'd3;
  localparam logic [3:0] ST_OFF = 4'b1000;
  localparam logic [3:0] ST_ON  = 4'b1001;
  localparam logic [3:0] ST_CC  = 4'b1011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b1;
  logic [3:0] chan_sel = SEL;

  midi_voice_alloc_if #(.NUM_VOICES(NV)) bus ();

  midi_voice_alloc #(.NUM_VOICES(NV), .AGE_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .chan_sel (chan_sel),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: voice table plus a countdown to the commit edge.
  bit         m_gate [NV];
  logic [6:0] m_note [NV];
  logic [6:0] m_vel  [NV];
  int         m_age  [NV];
  bit         m_ready_d = 1'b0;
  bit         m_acc;
  int         m_count = 0;
  int         m_op = 0;
  logic [6:0] m_cn, m_cv;
  bit         m_busy = 1'b0, m_done = 1'b0, m_drop = 1'b0;

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_gate[i] = 1'b0; m_note[i] = '0; m_vel[i] = '0; m_age[i] = 0;
    end
    m_ready_d = 1'b0; m_count = 0; m_busy = 1'b0; m_done = 1'b0; m_drop = 1'b0;
  endfunction

  function automatic void model_apply();
    int t;
    t = -1;
    for (int i = 0; i < NV; i++)
      if (t < 0 && m_gate[i] && m_note[i] == m_cn) t = i;
    if (m_op == 1) begin
      for (int i = 0; i < NV; i++) if (t < 0 && !m_gate[i]) t = i;
      if (t < 0) begin
        t = 0;
        for (int i = 1; i < NV; i++) if (m_age[i] > m_age[t]) t = i;
      end
      for (int i = 0; i < NV; i++) begin
        if (i == t) begin
          m_gate[i] = 1'b1; m_note[i] = m_cn; m_vel[i] = m_cv; m_age[i] = 0;
        end else if (m_age[i] < NV - 1) begin
          m_age[i] = m_age[i] + 1;
        end
      end
    end else if (m_op == 2) begin
      if (t >= 0) m_gate[t] = 1'b0;
    end else begin
      for (int i = 0; i < NV; i++) m_gate[i] = 1'b0;
    end
  endfunction

  initial model_reset();

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_reset();
    end else begin
      m_acc = bus.midi_command_ready && !m_ready_d && en && (bus.chan == chan_sel);
      m_ready_d = bus.midi_command_ready;
      m_done = 1'b0;
      m_drop = 1'b0;
      if (m_count > 0) begin
        if (m_acc) m_drop = 1'b1;
        m_count = m_count - 1;
        if (m_count == 0) begin
          model_apply();
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end else if (m_acc) begin
        m_cn = bus.note_in;
        m_cv = bus.velocity_in;
        if (bus.ch_message == ST_ON && bus.velocity_in != 0) begin
          m_op = 1; m_count = NV + 1; m_busy = 1'b1;
        end else if (bus.ch_message == ST_OFF || bus.ch_message == ST_ON) begin
          m_op = 2; m_count = NV + 1; m_busy = 1'b1;
        end else if (bus.ch_message == ST_CC && bus.note_in == 7'd123) begin
          m_op = 3; m_count = 1; m_busy = 1'b1;
        end
      end
    end
  end

  logic [NV-1:0]   e_gate;
  logic [7*NV-1:0] e_note, e_vel;

  always @(negedge clk) begin
    for (int i = 0; i < NV; i++) begin
      e_gate[i]       = m_gate[i];
      e_note[7*i +: 7] = m_note[i];
      e_vel[7*i +: 7]  = m_vel[i];
    end
    check("cyc gate", bus.gate, e_gate);
    check("cyc note_out", bus.note_out, e_note);
    check("cyc velocity_out", bus.velocity_out, e_vel);
    check("cyc busy", bus.busy, m_busy);
    check("cyc done", bus.done, m_done);
    check("cyc drop", bus.drop, m_drop);
  end

  task automatic do_reset();
    rst = 1'b0;
    bus.midi_command_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Edge lands at the next clock (E0); returns 1 time unit after E0.
  task automatic send(input logic [3:0] st, input logic [3:0] ch, input logic [6:0] n,
                      input logic [6:0] v);
    @(posedge clk); #1;
    bus.ch_message = st; bus.chan = ch; bus.note_in = n; bus.velocity_in = v;
    bus.midi_command_ready = 1'b1;
    @(posedge clk); #1;
    bus.midi_command_ready = 1'b0;
  endtask

  task automatic wait_done(input string name, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clk); #1;
      cyc = k + 1;
      if (bus.done) seen = 1'b1;
    end
    check({name, " done"}, seen, 1'b1);
  endtask

  task automatic note_on(input logic [6:0] n, input logic [6:0] v);
    int c;
    send(ST_ON, SEL, n, v);
    wait_done("note_on", c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    bus.midi_command_ready = 1'b0;
    bus.ch_message = '0; bus.chan = '0; bus.note_in = '0; bus.velocity_in = '0;

    // Reset state and first allocation latency
    do_reset();
    check("reset gate", bus.gate, 0);
    check("reset note_out", bus.note_out, 0);
    check("reset busy", bus.busy, 0);
    send(ST_ON, SEL, 7'd60, 7'd100);
    check("t1 busy after accept", bus.busy, 1);
    wait_done("t1", cyc);
    check("t1 latency", cyc, 5);
    check("t1 gate", bus.gate, 4'b0001);
    check("t1 note0", bus.note_out[6:0], 60);
    check("t1 vel0", bus.velocity_out[6:0], 100);
    @(posedge clk); #1;
    check("t1 busy cleared", bus.busy, 0);

    // Fill all voices then steal the oldest
    do_reset();
    note_on(7'd60, 7'd10); note_on(7'd62, 7'd20);
    note_on(7'd64, 7'd30); note_on(7'd67, 7'd40);
    check("t2 full gate", bus.gate, 4'b1111);
    note_on(7'd69, 7'd50);
    check("t2 steal gate", bus.gate, 4'b1111);
    check("t2 steal notes", bus.note_out, {7'd67, 7'd64, 7'd62, 7'd69});
    check("t2 steal vel0", bus.velocity_out[6:0], 50);
    note_on(7'd71, 7'd55);
    check("t2 second steal notes", bus.note_out, {7'd67, 7'd64, 7'd71, 7'd69});

    // Retrigger of a sounding note
    do_reset();
    note_on(7'd60, 7'd50);
    note_on(7'd60, 7'd90);
    check("t3 gate", bus.gate, 4'b0001);
    check("t3 vel0", bus.velocity_out[6:0], 90);
    check("t3 note1 untouched", bus.note_out[13:7], 0);

    // NoteOn vel 0 releases, NoteOff of an inactive note changes nothing
    do_reset();
    note_on(7'd62, 7'd80);
    send(ST_ON, SEL, 7'd62, 7'd0);
    wait_done("t4 off", cyc);
    check("t4 gate", bus.gate, 4'b0000);
    check("t4 note held", bus.note_out[6:0], 62);
    check("t4 vel held", bus.velocity_out[6:0], 80);
    send(ST_OFF, SEL, 7'd70, 7'd64);
    wait_done("t4 inactive off", cyc);
    check("t4 inactive notes", bus.note_out[6:0], 62);
    note_on(7'd65, 7'd33);
    send(ST_OFF, SEL, 7'd65, 7'd0);
    wait_done("t4 off v0", cyc);
    check("t4 off reused slot", bus.gate, 4'b0000);

    // Overlapping edge is dropped; foreign channel / disabled are ignored
    do_reset();
    @(posedge clk); #1;
    bus.ch_message = ST_ON; bus.chan = SEL; bus.note_in = 7'd64; bus.velocity_in = 7'd70;
    bus.midi_command_ready = 1'b1;
    @(posedge clk); #1;
    bus.midi_command_ready = 1'b0;
    @(posedge clk); #1;
    bus.note_in = 7'd65;
    bus.midi_command_ready = 1'b1;
    @(posedge clk); #1;
    check("t5 drop", bus.drop, 1);
    check("t5 busy during drop", bus.busy, 1);
    bus.midi_command_ready = 1'b0;
    wait_done("t5", cyc);
    check("t5 gate", bus.gate, 4'b0001);
    check("t5 note0", bus.note_out[6:0], 64);
    check("t5 note1", bus.note_out[13:7], 0);
    send(ST_ON, 4'd5, 7'd70, 7'd70);
    @(posedge clk); #1;
    check("t5 wrong chan busy", bus.busy, 0);
    check("t5 wrong chan drop", bus.drop, 0);
    en = 1'b0;
    send(ST_ON, SEL, 7'd71, 7'd70);
    @(posedge clk); #1;
    check("t5 disabled busy", bus.busy, 0);
    en = 1'b1;
    send(ST_CC, SEL, 7'd7, 7'd10);
    @(posedge clk); #1;
    check("t5 other cc busy", bus.busy, 0);
    repeat (6) @(posedge clk);
    #1 check("t5 final gate", bus.gate, 4'b0001);

    // All Notes Off commits one cycle after accept
    do_reset();
    note_on(7'd60, 7'd11); note_on(7'd62, 7'd22);
    note_on(7'd64, 7'd33); note_on(7'd67, 7'd44);
    send(ST_CC, SEL, 7'd123, 7'd0);
    @(posedge clk); #1;
    check("t6 cc done", bus.done, 1);
    check("t6 cc gate", bus.gate, 4'b0000);
    check("t6 cc notes held", bus.note_out, {7'd67, 7'd64, 7'd62, 7'd60});
    note_on(7'd50, 7'd5);
    check("t6 reuse voice0", bus.note_out[6:0], 50);

    // Reset in the middle of a scan
    send(ST_ON, SEL, 7'd72, 7'd40);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check("t6 rst gate", bus.gate, 0);
    check("t6 rst note_out", bus.note_out, 0);
    check("t6 rst velocity_out", bus.velocity_out, 0);
    check("t6 rst busy", bus.busy, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    #1 check("t6 after rst gate", bus.gate, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
